// File: rtl/tone_buzzer_if.sv
// Note/octave request and buzzer drive bundle between the learn/play stages and tone_buzzer.
interface tone_buzzer_if;
  logic       enable;
  logic [3:0] note;
  logic [1:0] octave;
  logic       buzzer;
  logic       playing;

  modport master (output enable, output note, output octave, input buzzer, input playing);
  modport slave  (input enable, input note, input octave, output buzzer, output playing);
endinterface

// File: rtl/tone_buzzer.sv
// Square-wave tone generator for a held note/octave code, with a silent
// articulation gap inserted on every note change.
module tone_buzzer #(
  parameter int unsigned CLK_HZ     = 100_000_000,
  parameter int unsigned GAP_CYCLES = 1_000_000,
  parameter int unsigned DIV_W      = 20
) (
  input  logic         clk,
  input  logic         reset,
  tone_buzzer_if.slave io
);

  localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [GAP_W-1:0] GAP_ZERO  = {GAP_W{1'b0}};
  localparam logic [GAP_W-1:0] GAP_ONE   = GAP_W'(1);
  localparam logic [DIV_W-1:0] HALF_ZERO = {DIV_W{1'b0}};
  localparam logic [DIV_W-1:0] HALF_ONE  = DIV_W'(1);

  // Middle-octave half periods; frequencies are in 0.01 Hz units, hence the x50.
  localparam logic [63:0] CLK_X50 = 64'(CLK_HZ) * 64'd50;
  localparam logic [DIV_W-1:0] HALF_C = DIV_W'(CLK_X50 / 64'd26163);
  localparam logic [DIV_W-1:0] HALF_D = DIV_W'(CLK_X50 / 64'd29366);
  localparam logic [DIV_W-1:0] HALF_E = DIV_W'(CLK_X50 / 64'd32963);
  localparam logic [DIV_W-1:0] HALF_F = DIV_W'(CLK_X50 / 64'd34923);
  localparam logic [DIV_W-1:0] HALF_G = DIV_W'(CLK_X50 / 64'd39200);
  localparam logic [DIV_W-1:0] HALF_A = DIV_W'(CLK_X50 / 64'd44000);
  localparam logic [DIV_W-1:0] HALF_B = DIV_W'(CLK_X50 / 64'd49388);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GAP  = 2'd1,
    ST_TONE = 2'd2
  } state_e;

  function automatic logic [DIV_W-1:0] half_of(input logic [5:0] key);
    logic [DIV_W-1:0] base;
    case (key[5:2])
      4'd1:    base = HALF_C;
      4'd2:    base = HALF_D;
      4'd3:    base = HALF_E;
      4'd4:    base = HALF_F;
      4'd5:    base = HALF_G;
      4'd6:    base = HALF_A;
      4'd7:    base = HALF_B;
      default: base = HALF_ZERO;
    endcase
    case (key[1:0])
      2'b01:   return base << 1;
      2'b10:   return base >> 1;
      default: return base;
    endcase
  endfunction

  state_e           state_q, state_d;
  logic [5:0]       key_q, key_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic [DIV_W-1:0] half_cnt_q, half_cnt_d;
  logic             buzzer_q, buzzer_d;
  logic             playing_q, playing_d;

  logic [5:0]       key_s;
  logic             sounding_s;
  logic             change_s;
  logic [DIV_W-1:0] half_s;
  logic             half_wrap_s;

  assign key_s       = {io.note, io.octave};
  assign sounding_s  = io.enable && (io.note >= 4'd1) && (io.note <= 4'd7);
  assign change_s    = (key_s != key_q);
  assign half_s      = half_of(key_q);
  assign half_wrap_s = (half_cnt_q == (half_s - HALF_ONE));

  // State, counters, latched code and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      key_q      <= 6'd0;
      gap_cnt_q  <= GAP_ZERO;
      half_cnt_q <= HALF_ZERO;
      buzzer_q   <= 1'b0;
      playing_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      key_q      <= key_d;
      gap_cnt_q  <= gap_cnt_d;
      half_cnt_q <= half_cnt_d;
      buzzer_q   <= buzzer_d;
      playing_q  <= playing_d;
    end
  end

  // Next state and counter updates.
  always_comb begin
    state_d    = state_q;
    gap_cnt_d  = gap_cnt_q;
    half_cnt_d = half_cnt_q;
    key_d      = change_s ? key_s : key_q;
    case (state_q)
      ST_IDLE: begin
        gap_cnt_d  = GAP_ZERO;
        half_cnt_d = HALF_ZERO;
        if (sounding_s) begin
          state_d = (GAP_CYCLES > 0) ? ST_GAP : ST_TONE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_GAP: begin
        half_cnt_d = HALF_ZERO;
        if (!sounding_s) begin
          state_d   = ST_IDLE;
          gap_cnt_d = GAP_ZERO;
        end else if (change_s) begin
          gap_cnt_d = GAP_ZERO;
        end else if (gap_cnt_q == GAP_LAST) begin
          state_d   = ST_TONE;
          gap_cnt_d = GAP_ZERO;
        end else begin
          gap_cnt_d = gap_cnt_q + GAP_ONE;
        end
      end
      ST_TONE: begin
        gap_cnt_d = GAP_ZERO;
        if (!sounding_s) begin
          state_d    = ST_IDLE;
          half_cnt_d = HALF_ZERO;
        end else if (change_s) begin
          state_d    = (GAP_CYCLES > 0) ? ST_GAP : ST_TONE;
          half_cnt_d = HALF_ZERO;
        end else if (half_wrap_s) begin
          half_cnt_d = HALF_ZERO;
        end else begin
          half_cnt_d = half_cnt_q + HALF_ONE;
        end
      end
      default: begin
        state_d    = ST_IDLE;
        gap_cnt_d  = GAP_ZERO;
        half_cnt_d = HALF_ZERO;
      end
    endcase
  end

  // Output decode; any entry into TONE (fresh or restarted) begins at a low phase.
  always_comb begin
    playing_d = (state_d == ST_TONE);
    if ((state_d == ST_TONE) && (state_q == ST_TONE) && !change_s) begin
      buzzer_d = half_wrap_s ? ~buzzer_q : buzzer_q;
    end else begin
      buzzer_d = 1'b0;
    end
  end

  assign io.buzzer  = buzzer_q;
  assign io.playing = playing_q;

endmodule
